// File: rtl/l2_port_arbiter_pkg.sv
// Shared types for the L2 request port: the memory operation carried by every request.
package l2_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_WRITE = 2'd1,
        MEM_FLUSH = 2'd2
    } memory_operation_e;

endpackage

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port between icache and dcache, grant locked per transaction,
// with a sticky watchdog for granted transactions that stop receiving data.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   ic_req_address,
    input  memory_operation_e ic_req_type,
    input  logic              ic_req_valid,
    input  logic [XLEN-1:0]   ic_word_to_store,
    output logic [XLEN-1:0]   ic_fetched_word,
    output logic              ic_fetched_word_valid,
    input  logic [XLEN-1:0]   dc_req_address,
    input  memory_operation_e dc_req_type,
    input  logic              dc_req_valid,
    input  logic [XLEN-1:0]   dc_word_to_store,
    output logic [XLEN-1:0]   dc_fetched_word,
    output logic              dc_fetched_word_valid,
    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    output logic [XLEN-1:0]   l2_word_to_store,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_fetched_word_valid,
    output logic              timeout_error
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WDOG_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic          LAST_IC  = 1'b0;
    localparam logic          LAST_DC  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IC,
        GRANT_DC
    } state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic          timeout_q, timeout_d;
    logic          entering_grant;

    // A released requester hands straight over to a waiting peer on the same edge.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (dc_req_valid && (!ic_req_valid || last_grant_q == LAST_IC)) begin
                    state_d = GRANT_DC;
                end else if (ic_req_valid) begin
                    state_d = GRANT_IC;
                end
            end
            GRANT_IC: begin
                if (!ic_req_valid) begin
                    last_grant_d = LAST_IC;
                    state_d      = dc_req_valid ? GRANT_DC : IDLE;
                end
            end
            GRANT_DC: begin
                if (!dc_req_valid) begin
                    last_grant_d = LAST_DC;
                    state_d      = ic_req_valid ? GRANT_IC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign entering_grant = (state_d != state_q) && (state_d != IDLE);

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE || entering_grant || l2_fetched_word_valid) begin
            wdog_d = '0;
        end else if (l2_req_valid && wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + CW'(1);
        end
        timeout_d = timeout_q | (wdog_d == WDOG_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_IC;
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            timeout_q    <= timeout_d;
        end
    end

    assign timeout_error = timeout_q;

    // Responses arriving while idle are routed to nobody and simply dropped.
    always_comb begin
        l2_req_address        = '0;
        l2_req_type           = MEM_READ;
        l2_req_valid          = 1'b0;
        l2_word_to_store      = '0;
        ic_fetched_word       = '0;
        ic_fetched_word_valid = 1'b0;
        dc_fetched_word       = '0;
        dc_fetched_word_valid = 1'b0;
        case (state_q)
            GRANT_IC: begin
                l2_req_address        = ic_req_address;
                l2_req_type           = ic_req_type;
                l2_req_valid          = ic_req_valid;
                l2_word_to_store      = ic_word_to_store;
                ic_fetched_word       = l2_fetched_word;
                ic_fetched_word_valid = l2_fetched_word_valid;
            end
            GRANT_DC: begin
                l2_req_address        = dc_req_address;
                l2_req_type           = dc_req_type;
                l2_req_valid          = dc_req_valid;
                l2_word_to_store      = dc_word_to_store;
                dc_fetched_word       = l2_fetched_word;
                dc_fetched_word_valid = l2_fetched_word_valid;
            end
            default: ;
        endcase
    end

endmodule
